// File: rtl/m55_xfer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : m55_xfer
//  Description : Client-side LOAD/UNLOAD sequencer for the 5x5x64-bit lane
//                store. Lanes stream in/out in x-fastest order.
//  Revision    : 1.0 - initial release
// ============================================================================
module m55_xfer #(
    parameter int X_DIM = 5,
    parameter int Y_DIM = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_load,
    input  logic        start_unload,
    output logic        busy,
    output logic        done,
    input  logic [63:0] in_lane,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] out_lane,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  rx,
    output logic [2:0]  ry,
    input  logic [63:0] rd,
    output logic [2:0]  wx,
    output logic [2:0]  wy,
    output logic        wr,
    output logic [63:0] wd
);

    localparam int                 c_LANES = X_DIM * Y_DIM;
    localparam int                 c_CNT_W = $clog2(c_LANES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_LANES - 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(c_LANES);
    localparam logic [2:0]         c_XMAX  = 3'(X_DIM - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_UNLOAD = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_acc;
    logic [c_CNT_W-1:0] r_fetch;
    logic [c_CNT_W-1:0] r_deliv;
    logic [2:0]         r_wpx, r_wpy;
    logic [2:0]         r_rpx, r_rpy;
    logic [2:0]         r_wx, r_wy;
    logic [63:0]        r_wd;
    logic               r_wr;
    logic [63:0]        r_out_lane;
    logic               r_out_valid;
    logic               r_load_last;
    logic               r_done;

    logic w_go_load, w_go_unload;
    logic w_in_ready, w_in_fire;
    logic w_fetch, w_out_fire, w_unload_last;

    assign w_go_load     = (r_state == S_IDLE) && start_load;
    assign w_go_unload   = (r_state == S_IDLE) && !start_load && start_unload;
    assign w_in_ready    = (r_state == S_LOAD) && (r_acc != c_FULL);
    assign w_in_fire     = w_in_ready && in_valid;
    assign w_fetch       = (r_state == S_UNLOAD) && (r_fetch != c_FULL) &&
                           (!r_out_valid || out_ready);
    assign w_out_fire    = r_out_valid && out_ready;
    assign w_unload_last = w_out_fire && (r_deliv == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go_load)        w_state_nxt = S_LOAD;
                else if (w_go_unload) w_state_nxt = S_UNLOAD;
            end
            S_LOAD: begin
                if (w_in_fire && (r_acc == c_LAST)) w_state_nxt = S_IDLE;
            end
            S_UNLOAD: begin
                if (w_unload_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Write side: one registered write per accepted lane
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_wpx       <= '0;
            r_wpy       <= '0;
            r_wx        <= '0;
            r_wy        <= '0;
            r_wd        <= '0;
            r_wr        <= 1'b0;
            r_load_last <= 1'b0;
        end else begin
            r_wr        <= w_in_fire;
            r_load_last <= w_in_fire && (r_acc == c_LAST);
            if (w_go_load) begin
                r_acc <= '0;
                r_wpx <= '0;
                r_wpy <= '0;
            end else if (w_in_fire) begin
                r_wd  <= in_lane;
                r_wx  <= r_wpx;
                r_wy  <= r_wpy;
                r_acc <= r_acc + 1'b1;
                if (r_wpx == c_XMAX) begin
                    r_wpx <= '0;
                    r_wpy <= r_wpy + 3'd1;
                end else begin
                    r_wpx <= r_wpx + 3'd1;
                end
            end
        end
    end

    // Read side: read pointer runs ahead of the output register by one lane
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch     <= '0;
            r_deliv     <= '0;
            r_rpx       <= '0;
            r_rpy       <= '0;
            r_out_lane  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_go_unload) begin
                r_fetch <= '0;
                r_deliv <= '0;
                r_rpx   <= '0;
                r_rpy   <= '0;
            end else begin
                if (w_fetch) begin
                    r_out_lane  <= rd;
                    r_out_valid <= 1'b1;
                    r_fetch     <= r_fetch + 1'b1;
                    if (r_fetch != c_LAST) begin
                        if (r_rpx == c_XMAX) begin
                            r_rpx <= '0;
                            r_rpy <= r_rpy + 3'd1;
                        end else begin
                            r_rpx <= r_rpx + 3'd1;
                        end
                    end
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
                if (w_out_fire) begin
                    r_deliv <= r_deliv + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= r_load_last || w_unload_last;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign in_ready  = w_in_ready;
    assign out_lane  = r_out_lane;
    assign out_valid = r_out_valid;
    assign rx        = r_rpx;
    assign ry        = r_rpy;
    assign wx        = r_wx;
    assign wy        = r_wy;
    assign wr        = r_wr;
    assign wd        = r_wd;

endmodule
`default_nettype wire

// File: tb/tb_m55_xfer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_m55_xfer
//  Description : Self-checking bench for m55_xfer with a behavioural lane store.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m55_xfer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_load, start_unload;
    logic        busy, done;
    logic [63:0] in_lane;
    logic        in_valid, in_ready;
    logic [63:0] out_lane;
    logic        out_valid, out_ready;
    logic [2:0]  rx, ry, wx, wy;
    logic [63:0] rd, wd;
    logic        wr;

    m55_xfer #(.X_DIM(5), .Y_DIM(5)) dut (
        .clk(clk), .rst(rst), .start_load(start_load), .start_unload(start_unload),
        .busy(busy), .done(done), .in_lane(in_lane), .in_valid(in_valid),
        .in_ready(in_ready), .out_lane(out_lane), .out_valid(out_valid),
        .out_ready(out_ready), .rx(rx), .ry(ry), .rd(rd), .wx(wx), .wy(wy),
        .wr(wr), .wd(wd)
    );

    always #5 clk = ~clk;

    // Behavioural lane store
    logic [63:0] mem [0:24];
    always @(posedge clk) if (wr) mem[int'(wy) * 5 + int'(wx)] <= wd;
    assign rd = mem[int'(ry) * 5 + int'(rx)];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  x;
        logic [2:0]  y;
        logic [63:0] d;
        int          c;
    } wrec_t;

    wrec_t       wlog[$];
    logic [63:0] olog[$];
    int          ocyc[$];
    int          done_cyc[$];
    int          acc_cyc[$];
    logic [63:0] exp_store [25];
    logic        prev_stall = 1'b0;
    logic [63:0] prev_lane;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr) wlog.push_back('{wx, wy, wd, cyc});
            if (out_valid && out_ready) begin
                olog.push_back(out_lane);
                ocyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            if (prev_stall) begin
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_lane", out_lane, prev_lane);
            end
            prev_stall = out_valid && !out_ready;
            prev_lane  = out_lane;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check_reset_vals();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_lane", out_lane, 64'd0);
        check("rst_raddr", {58'd0, ry, rx}, 64'd0);
        check("rst_waddr", {58'd0, wy, wx}, 64'd0);
        check("rst_wr", {63'd0, wr}, 64'd0);
        check("rst_wd", wd, 64'd0);
    endtask

    // vmode: 0 valid always, 1 toggling, 2 random. abort_at>0 stops after that many accepts.
    task automatic do_load(input int vmode, input bit rnd_data, input bit poke_unload,
                           input int abort_at);
        int acc = 0;
        int k = 0;
        int s;
        logic [63:0] lane;
        wlog.delete(); done_cyc.delete(); acc_cyc.delete();
        start_load = 1'b1;
        s = cyc;
        step();
        start_load = 1'b0;
        check("load_busy_start", {63'd0, busy}, 64'd1);
        while (acc < 25 && k < 300) begin
            in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
            lane = rnd_data ? {$urandom, $urandom} : 64'h1000 + 64'(acc);
            in_lane = lane;
            start_unload = poke_unload && (k == 3);
            check("load_busy", {63'd0, busy}, 64'd1);
            if (poke_unload) check("load_no_out_valid", {63'd0, out_valid}, 64'd0);
            if (in_valid && in_ready) begin
                exp_store[acc] = lane;
                acc_cyc.push_back(cyc);
                acc++;
            end
            step();
            k++;
            if (abort_at > 0 && acc == abort_at) break;
        end
        in_valid = 1'b0;
        start_unload = 1'b0;
        if (abort_at > 0) return;
        check("load_accept_count", 64'(acc), 64'd25);
        if (acc != 25) return;
        k = 0;
        while (!done && k < 10) begin step(); k++; end
        check("load_done", {63'd0, done}, 64'd1);
        check("load_done_cycle", 64'(cyc), 64'(acc_cyc[24] + 2));
        if (vmode == 0) begin
            check("load_first_accept", 64'(acc_cyc[0]), 64'(s + 1));
            check("load_last_accept", 64'(acc_cyc[24]), 64'(s + 25));
        end
        step();
        check("load_wr_count", 64'(wlog.size()), 64'd25);
        check("load_done_pulses", 64'(done_cyc.size()), 64'd1);
        for (int i = 0; i < 25 && i < wlog.size(); i++) begin
            check("load_wx", {61'd0, wlog[i].x}, 64'(i % 5));
            check("load_wy", {61'd0, wlog[i].y}, 64'(i / 5));
            check("load_wd", wlog[i].d, exp_store[i]);
            check("load_wr_cycle", 64'(wlog[i].c), 64'(acc_cyc[i] + 1));
        end
    endtask

    // rmode: 0 ready always, 1 random, 2 stall 10 cycles on the last lane
    task automatic do_unload(input int rmode);
        int k = 0;
        int nh = 0;
        int stall = 0;
        int s;
        olog.delete(); ocyc.delete(); done_cyc.delete();
        start_unload = 1'b1;
        s = cyc;
        step();
        start_unload = 1'b0;
        check("unload_busy_start", {63'd0, busy}, 64'd1);
        check("unload_in_ready", {63'd0, in_ready}, 64'd0);
        while (!done && k < 400) begin
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && nh == 24 && stall < 10) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (out_valid && out_ready) nh++;
            step();
            k++;
        end
        check("unload_done", {63'd0, done}, 64'd1);
        check("unload_busy_at_done", {63'd0, busy}, 64'd0);
        if (ocyc.size() > 0) check("unload_done_after_last", 64'(cyc), 64'(ocyc[$] + 1));
        if (rmode == 0) begin
            check("unload_done_cycle", 64'(cyc), 64'(s + 27));
            if (ocyc.size() > 0) check("unload_first_lane_cycle", 64'(ocyc[0]), 64'(s + 2));
        end
        if (rmode == 2) check("unload_stall_len", 64'(stall), 64'd10);
        out_ready = 1'b0;
        step();
        check("unload_valid_after", {63'd0, out_valid}, 64'd0);
        check("unload_lane_count", 64'(olog.size()), 64'd25);
        check("unload_done_pulses", 64'(done_cyc.size()), 64'd1);
        for (int i = 0; i < 25 && i < olog.size(); i++)
            check("unload_lane", olog[i], exp_store[i]);
    endtask

    typedef struct {
        logic sl;
        logic su;
        logic e_busy;
        logic e_in_ready;
        logic e_out_valid;
    } vec_t;

    vec_t tbl[4];
    int   nw;

    initial begin
        rst = 1'b1;
        start_load = 1'b0; start_unload = 1'b0;
        in_lane = '0; in_valid = 1'b0; out_ready = 1'b0;
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        repeat (3) step();
        check_reset_vals();
        rst = 1'b0;
        step();

        // Start decoding from IDLE
        for (int i = 0; i < 4; i++) begin
            start_load = tbl[i].sl;
            start_unload = tbl[i].su;
            step();
            start_load = 1'b0;
            start_unload = 1'b0;
            check("tbl_busy", {63'd0, busy}, {63'd0, tbl[i].e_busy});
            check("tbl_in_ready", {63'd0, in_ready}, {63'd0, tbl[i].e_in_ready});
            step();
            check("tbl_out_valid", {63'd0, out_valid}, {63'd0, tbl[i].e_out_valid});
            rst = 1'b1;
            #1;
            check("tbl_abort_busy", {63'd0, busy}, 64'd0);
            step();
            rst = 1'b0;
            step();
        end

        do_load(0, 1'b0, 1'b0, 0);
        do_unload(0);

        do_load(1, 1'b0, 1'b1, 0);
        do_unload(1);

        // Reset in the middle of a load
        do_load(0, 1'b1, 1'b0, 10);
        in_valid = 1'b1;
        rst = 1'b1;
        #1;
        check_reset_vals();
        nw = wlog.size();
        step();
        rst = 1'b0;
        repeat (5) step();
        in_valid = 1'b0;
        check("abort_no_wr", 64'(wlog.size()), 64'(nw));
        check("abort_no_done", 64'(done_cyc.size()), 64'd0);
        check("abort_idle", {63'd0, busy}, 64'd0);

        do_load(2, 1'b1, 1'b0, 0);
        do_unload(2);
        do_load(0, 1'b1, 1'b0, 0);
        do_unload(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
